apb_arbiter_n: RTL

Parametrised N-requester arbiter with an APB3 slave configuration port, succeeding the fixed 4-requester arbiter_top. It sits between N bus masters' request lines and a shared resource. It supports fixed-priority, round-robin and hold (lock) round-robin modes, plus a software bypass request path. All grants are registered, one-hot-or-zero, and programmable at run time over APB.

---
 rtl/arb_pkg.sv | 41 ++++
 rtl/apb_arbiter_n_if.sv | 36 +++
 rtl/arb_core.sv | 64 ++++++
 rtl/apb_arbiter_n.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared types and constants for apb_arbiter_n. Holds the
//               arbitration mode enum, the APB register offsets, the CTRL
//               bit positions and the CTRL MODE field decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_HOLD  = 2'd2
  } arb_mode_e;

  // Byte offsets of the APB registers
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_SW_REQ   = 8'h04;
  localparam logic [7:0] REG_GNT_STAT = 8'h08;
  localparam logic [7:0] REG_REQ_STAT = 8'h0C;
  localparam logic [7:0] REG_GNT_CNT  = 8'h10;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BYPASS_BIT  = 1;
  localparam int CTRL_MODE_LSB    = 2;
  localparam int CTRL_CNT_CLR_BIT = 4;

  // The raw MODE field is stored as written; the reserved encoding 3
  // behaves as fixed priority.
  function automatic arb_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return ARB_RR;
      2'd2:    return ARB_HOLD;
      default: return ARB_FIXED;
    endcase
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/apb_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Interface   : apb_arbiter_n_if
// Description : APB3 configuration bus for apb_arbiter_n.
// Signals     : PSEL, PENABLE, PWRITE, PADDR[ADDR_W], PWDATA[DATA_W]
//               (master -> slave); PRDATA[DATA_W], PREADY, PSLVERR
//               (slave -> master).
// Modports    : master (bus driver / testbench), slave (arbiter).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_arbiter_n_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface : apb_arbiter_n_if
`default_nettype wire

// File: rtl/arb_core.sv
`default_nettype none
// ============================================================================
// Module      : arb_core
// Description : Combinational grant search. Fixed mode picks the lowest
//               set ereq bit; RR/hold modes search from ptr+1 upward with
//               wrap N-1 -> 0 (hold override lives in the caller).
// Ports       : ereq[N]      effective request vector
//               mode         decoded arbitration mode
//               ptr[IDX_W]   index of the last round-robin winner
//               gnt_nxt[N]   one-hot-or-zero candidate grant
//               win_idx      index of the winner (0 when none)
//               win_valid    at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module arb_core
  import arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     ereq,
  input  arb_mode_e        mode,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_nxt,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [IDX_W:0] cand;

  // Both searches scan from the lowest priority candidate to the highest
  // so the last hit recorded is the winner; no early-exit flag needed.
  always_comb begin
    gnt_nxt   = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    if (mode == ARB_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (ereq[i]) begin
          win_idx   = IDX_W'(i);
          win_valid = 1'b1;
        end
      end
    end else begin
      // Offset k = N lands back on ptr itself, so it is the last resort.
      for (int k = N; k >= 1; k--) begin
        cand = {1'b0, ptr} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(N)) begin
          cand = cand - (IDX_W+1)'(N);
        end
        if (ereq[cand[IDX_W-1:0]]) begin
          win_idx   = cand[IDX_W-1:0];
          win_valid = 1'b1;
        end
      end
    end
    if (win_valid) begin
      gnt_nxt[win_idx] = 1'b1;
    end
  end

endmodule : arb_core
`default_nettype wire

// File: rtl/apb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : apb_arbiter_n
// Description : N-requester arbiter (fixed / round-robin / hold round-robin)
//               with software bypass requests and an APB3 register port.
//               Grant is registered, one-hot or zero, 1-cycle latency.
// Ports       : PCLK      clock for APB and arbitration
//               PRESETn   asynchronous active-low reset
//               apb       APB3 slave (apb_arbiter_n_if.slave)
//               req[N]    hardware requests
//               gnt[N]    registered grant
// Options     : ARB_GNT_CNT_EN - adds the 32-bit saturating new-grant
//               counter at offset 0x10; otherwise 0x10 is unmapped.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arbiter_n
  import arb_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_arbiter_n_if.slave apb,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Register state
  logic             en_q, en_d;
  logic             bypass_q, bypass_d;
  logic [1:0]       mode_q, mode_d;
  logic [N-1:0]     sw_req_q, sw_req_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // APB decode
  logic              access;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              hit_ctrl, hit_sw_req, hit_gnt_stat, hit_req_stat, hit_cnt;
  logic              mapped;
  logic [DATA_W-1:0] rdata;
  logic              cnt_clr;
  logic [31:0]       cnt_rd;

  // Arbitration
  arb_mode_e        mode;
  logic [N-1:0]     ereq;
  logic [N-1:0]     core_gnt;
  logic [IDX_W-1:0] core_idx;
  logic             core_valid;

  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = access & apb.PWRITE;
  assign addr   = {apb.PADDR[ADDR_W-1:2], 2'b00};

  assign hit_ctrl     = (addr == ADDR_W'(REG_CTRL));
  assign hit_sw_req   = (addr == ADDR_W'(REG_SW_REQ));
  assign hit_gnt_stat = (addr == ADDR_W'(REG_GNT_STAT));
  assign hit_req_stat = (addr == ADDR_W'(REG_REQ_STAT));

  // Register-file next state; RO and unmapped writes simply fall through.
  always_comb begin
    en_d     = en_q;
    bypass_d = bypass_q;
    mode_d   = mode_q;
    sw_req_d = sw_req_q;
    cnt_clr  = 1'b0;
    if (wr && hit_ctrl) begin
      en_d     = apb.PWDATA[CTRL_EN_BIT];
      bypass_d = apb.PWDATA[CTRL_BYPASS_BIT];
      mode_d   = apb.PWDATA[CTRL_MODE_LSB +: 2];
      cnt_clr  = apb.PWDATA[CTRL_CNT_CLR_BIT];
    end
    if (wr && hit_sw_req) begin
      sw_req_d = apb.PWDATA[N-1:0];
    end
  end

  // Registered values only, so writes influence arbitration one cycle later
  // and a same-cycle SW_REQ write sees the old value.
  assign mode = decode_mode(mode_q);
  assign ereq = bypass_q ? sw_req_q : req;

  arb_core #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_core (
    .ereq      (ereq),
    .mode      (mode),
    .ptr       (ptr_q),
    .gnt_nxt   (core_gnt),
    .win_idx   (core_idx),
    .win_valid (core_valid)
  );

  // Hold keeps the current owner while it still requests. ptr only tracks
  // round-robin winners so fixed-mode traffic does not disturb RR fairness.
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (!en_q) begin
      gnt_d = '0;
    end else if ((mode == ARB_HOLD) && ((gnt_q & ereq) != '0)) begin
      gnt_d = gnt_q;
    end else begin
      gnt_d = core_gnt;
      if (core_valid && (mode != ARB_FIXED)) begin
        ptr_d = core_idx;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q     <= 1'b1;
      bypass_q <= 1'b0;
      mode_q   <= 2'd0;
      sw_req_q <= '0;
      gnt_q    <= '0;
      ptr_q    <= IDX_W'(N - 1);
    end else begin
      en_q     <= en_d;
      bypass_q <= bypass_d;
      mode_q   <= mode_d;
      sw_req_q <= sw_req_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef ARB_GNT_CNT_EN
  logic [31:0] gnt_cnt_q, gnt_cnt_d;

  // Counting on gnt_d lines the increment up with the edge that loads the
  // new grant; a new grant is nonzero and differs from the current one.
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (cnt_clr) begin
      gnt_cnt_d = '0;
    end else if ((gnt_d != '0) && (gnt_d != gnt_q) && (gnt_cnt_q != '1)) begin
      gnt_cnt_d = gnt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign hit_cnt = (addr == ADDR_W'(REG_GNT_CNT));
  assign cnt_rd  = gnt_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{apb.PWDATA, apb.PADDR[1:0]};
`else
  assign hit_cnt = 1'b0;
  assign cnt_rd  = '0;

  logic unused_bits;
  assign unused_bits = ^{apb.PWDATA, apb.PADDR[1:0], cnt_clr, REG_GNT_CNT};
`endif

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    if (hit_ctrl) begin
      rdata[CTRL_EN_BIT]        = en_q;
      rdata[CTRL_BYPASS_BIT]    = bypass_q;
      rdata[CTRL_MODE_LSB +: 2] = mode_q;
    end else if (hit_sw_req) begin
      rdata[N-1:0] = sw_req_q;
    end else if (hit_gnt_stat) begin
      rdata[N-1:0] = gnt_q;
    end else if (hit_req_stat) begin
      rdata[N-1:0] = ereq;
    end else if (hit_cnt) begin
      rdata = DATA_W'(cnt_rd);
    end else begin
      mapped = 1'b0;
    end
  end

  assign apb.PRDATA  = (access && !apb.PWRITE && mapped) ? rdata : '0;
  assign apb.PSLVERR = access & ~mapped;
  assign apb.PREADY  = 1'b1;
  assign gnt         = gnt_q;

endmodule : apb_arbiter_n
`default_nettype wire
